updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised successor to the team's 3-bit down-counter.
- Up/down counter with configurable width, terminal value and reset value.
- Built-in enable prescaler, synchronous load, and three boundary modes: wrap, saturate and one-shot.
- Used as a general event/timeout counter; emits a registered terminal-count pulse and a one-shot done flag.

Parameters:
- WIDTH, 3: counter width in bits (>=1).
- MAX_VAL, 2**WIDTH-1: upper terminal value; count range is 0..MAX_VAL.
- RST_VAL, MAX_VAL: count value after reset. Must be <=MAX_VAL.
- PRESC, 1: enabled cycles per count step (>=1); 1 means step on every enabled cycle.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- en  in  1  count enable; gates the prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- mode  in  2  boundary mode: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap)
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value written on load
- count  out  WIDTH  current count (registered)
- tc  out  1  one-cycle terminal-count pulse (registered)
- done  out  1  one-shot complete flag (registered)

Behaviour:
- Reset (reset=0, async):
  - count=RST_VAL, tc=0, done=0.
  - Prescaler count=0; FSM=RUN.
  - Leaving reset takes effect at the next clk edge.
- Priority per edge: reset > load > step.
- Load:
  - count = min(load_val, MAX_VAL); prescaler cleared; tc=0; done=0; FSM=RUN.
  - Load is honoured in any state, whether or not en is high.
- Prescaler:
  - Internal count p, 0..PRESC-1, advances only when en=1 and FSM=RUN.
  - A step occurs on an edge where en=1 and p==PRESC-1; p then returns to 0.
  - With PRESC=1, every enabled edge is a step.
  - en=0 holds p; it does not clear it.
- Step, non-boundary: count ±1 per up; tc=0.
- Boundary event: a step with up=1 and count==MAX_VAL, or up=0 and count==0.
  - wrap: count becomes 0 (up) or MAX_VAL (down); tc=1 for exactly one cycle.
  - saturate: count holds; tc=1 on every step attempted at the boundary.
  - one-shot: count holds; tc=1 once; done=1; FSM->DONE.
- tc latency: high in the cycle immediately after the edge on which the boundary step occurs; low otherwise.
- FSM states:
  - RUN: normal counting.
  - DONE: en ignored, count frozen, done held high, tc=0. Only load or reset leaves DONE (both go to RUN).
  - Mode changes other than load never leave DONE.
- Simultaneous events:
  - load and a step on the same edge: load wins and the step is discarded (no tc).
  - up or mode changes apply to the next step; no pipeline flush.
- MAX_VAL < 2**WIDTH-1: count never exceeds MAX_VAL; out-of-range load_val is clamped.
- Reset mid-run, including mid-prescale: all state returns to reset values immediately.
- All arithmetic is unsigned WIDTH bits. No overflow is possible because boundaries are checked before ±1.

Decomposition:
- Package counter_pkg holds:
  - mode encodings MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10;
  - FSM state encoding RUN/DONE;
  - a clog2 helper for the prescaler width.
- One sub-module, tick_prescaler:
  - ports clk, reset (async active-low), en, clr, tick;
  - parameter PRESC;
  - generates the step strobe; clr is driven by load.
- The counter/FSM stays in the top module.

Test Plan:
1. WIDTH=3, PRESC=1, mode=wrap, up=0, en=1 from reset -> count 7,6,5,...,0,7; tc high the cycle count shows 7 after 0; done=0 throughout.
2. mode=saturate, up=1, load_val=5, load pulse, then en=1 for 4 cycles -> count 5,6,7,7,7; tc high on the 2nd and 3rd cycles after count reaches 7; count never wraps.
3. mode=one-shot, up=0, load_val=2, load, en=1 -> count 2,1,0, then frozen at 0; tc single pulse; done=1. Further en has no effect. A new load of 3 clears done and restarts the count from 3.
4. PRESC=3, mode=wrap, up=1, en toggled 1,1,0,1 -> count increments only on the 3rd enabled cycle (en=0 pauses, does not restart). Load mid-prescale clears p; the next step needs 3 more enabled cycles.
5. MAX_VAL=5, WIDTH=3: load_val=7 -> count=5. Then up=1, wrap -> 0 with tc. Load and step on the same edge -> count=load_val, tc=0.
6. reset asserted mid-count and mid-prescale (count=4, p=1) -> count=RST_VAL, tc=0, done=0 asynchronously, before the next clk edge. Counting resumes from RST_VAL after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_*  : boundary-mode encodings on the mode input (2'b11 behaves as wrap)
//   state_e : counter FSM state (RUN counts, DONE is the frozen one-shot state)
//   clog2   : ceiling log2 with a floor of 1, used to size the prescaler register
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Never returns 0, so PRESC=1 still gets a 1-bit register.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits a step strobe on every PRESC-th enabled cycle.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   en    : advance enable (caller already gates this with the RUN state)
//   clr   : synchronous clear of the phase counter, takes priority over en
//   tick  : combinational strobe, high on the enabled cycle that completes a period
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = clog2(PRESC);
    localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

    logic [PW-1:0] r_p;
    logic          w_last;

    assign w_last = (r_p == LAST);
    assign tick   = en && w_last;

    // en=0 holds the phase rather than clearing it, so a paused count resumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p <= '0;
        end else if (clr) begin
            r_p <= '0;
        end else if (en) begin
            r_p <= w_last ? '0 : r_p + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down event/timeout counter.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   en       : count enable (feeds the prescaler)
//   up       : 1 = increment, 0 = decrement
//   mode     : boundary behaviour (wrap / saturate / one-shot, 11 = wrap)
//   load     : synchronous load strobe, beats any step on the same edge
//   load_val : value to load, clamped to MAX_VAL
//   count    : registered count, always within 0..MAX_VAL
//   tc       : registered one-cycle terminal-count pulse
//   done     : registered one-shot complete flag
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int RST_VAL = MAX_VAL,
    parameter int PRESC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic             w_tick;
    logic             w_at_bnd;
    logic [WIDTH-1:0] w_load_clamped;

    // Prescaler only advances while running; DONE freezes it along with the count.
    tick_prescaler #(
        .PRESC (PRESC)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en && (r_state == ST_RUN)),
        .clr   (load),
        .tick  (w_tick)
    );

    // Boundary is detected before the +/-1, so the arithmetic never overflows.
    assign w_at_bnd       = up ? (r_count == MAX_W) : (r_count == '0);
    assign w_load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_count <= RST_W;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_state <= ST_RUN;
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_tc    <= 1'b0;
            r_done  <= 1'b1;
        end else if (w_tick) begin
            if (w_at_bnd) begin
                r_tc <= 1'b1;
                case (mode)
                    MODE_SAT: begin
                        r_count <= r_count;
                    end
                    MODE_ONESHOT: begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_count <= up ? '0 : MAX_W;
                    end
                endcase
            end else begin
                r_count <= up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = r_done;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: two instances share one stimulus stream.
//   A: WIDTH=3, MAX=7, RST=7, PRESC=1   B: WIDTH=3, MAX=5, RST=3, PRESC=3
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] load_val = 3'd0;
    logic [2:0] count_a, count_b;
    logic       tc_a, tc_b, done_a, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(3)) dut_a (
        .clk(clk), .reset(rst_n), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .done(done_a)
    );

    updown_counter_param #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(3), .PRESC(3)) dut_b (
        .clk(clk), .reset(rst_n), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .done(done_b)
    );

    // Reference model: count kept as an integer, wrap expressed as modular arithmetic.
    typedef struct {
        int cnt;
        int p;
        bit tc;
        bit done;
    } model_t;

    model_t ma, mb;

    function automatic model_t mreset(int rst);
        model_t m;
        m.cnt = rst; m.p = 0; m.tc = 0; m.done = 0;
        return m;
    endfunction

    function automatic model_t mstep(model_t m, int maxv, int presc,
                                     bit e, bit u, bit [1:0] md, bit ld, int lv);
        model_t n;
        int     nxt;
        bit     bnd;
        n = m;
        n.tc = 0;
        if (ld) begin
            n.cnt = (lv > maxv) ? maxv : lv;
            n.p = 0; n.done = 0;
            return n;
        end
        if (m.done || !e) return n;
        if (m.p < presc - 1) begin
            n.p = m.p + 1;
            return n;
        end
        n.p = 0;
        nxt = (m.cnt + (u ? 1 : maxv)) % (maxv + 1);
        bnd = u ? (m.cnt == maxv) : (m.cnt == 0);
        if (!bnd) begin
            n.cnt = nxt;
        end else begin
            n.tc = 1;
            if (md == 2'b01) n.cnt = m.cnt;
            else if (md == 2'b10) n.done = 1;
            else n.cnt = nxt;
        end
        return n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_models(string tag);
        chk({tag, ".a.count"}, int'(count_a), ma.cnt);
        chk({tag, ".a.tc"},    int'(tc_a),    int'(ma.tc));
        chk({tag, ".a.done"},  int'(done_a),  int'(ma.done));
        chk({tag, ".b.count"}, int'(count_b), mb.cnt);
        chk({tag, ".b.tc"},    int'(tc_b),    int'(mb.tc));
        chk({tag, ".b.done"},  int'(done_b),  int'(mb.done));
    endtask

    // Called at posedge+1: inputs held across the next edge, then checked at posedge+1.
    task automatic step(string tag, bit e, bit u, bit [1:0] md, bit ld, bit [2:0] lv);
        en = e; up = u; mode = md; load = ld; load_val = lv;
        @(posedge clk);
        #1;
        ma = mstep(ma, 7, 1, e, u, md, ld, int'(lv));
        mb = mstep(mb, 5, 3, e, u, md, ld, int'(lv));
        cmp_models(tag);
    endtask

    // Asynchronous reset pulse entirely between two clock edges.
    task automatic do_reset(string tag);
        #1;
        rst_n = 1'b0;
        #1;
        ma = mreset(7);
        mb = mreset(3);
        chk({tag, ".a.count"}, int'(count_a), 7);
        chk({tag, ".b.count"}, int'(count_b), 3);
        chk({tag, ".tc"},      int'(tc_a | tc_b), 0);
        chk({tag, ".done"},    int'(done_a | done_b), 0);
        #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit       e, u;
        bit [1:0] md;
        bit       ld;
        bit [2:0] lv;
        int       ecnt;
        bit       etc, edone;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit e, bit u, bit [1:0] md, bit ld, bit [2:0] lv,
                                int ecnt, bit etc, bit edone);
        vec_t v;
        v.e = e; v.u = u; v.md = md; v.ld = ld; v.lv = lv;
        v.ecnt = ecnt; v.etc = etc; v.edone = edone;
        return v;
    endfunction

    initial begin
        // Expected outputs of instance A (MAX=7, PRESC=1) after each edge.
        // Wrap countdown from reset.
        for (int i = 6; i >= 0; i--) tv.push_back(mk(1, 0, 2'b00, 0, 0, i, 0, 0));
        tv.push_back(mk(1, 0, 2'b00, 0, 0, 7, 1, 0));
        tv.push_back(mk(1, 0, 2'b00, 0, 0, 6, 0, 0));
        // Saturate upward from a load of 5.
        tv.push_back(mk(0, 1, 2'b01, 1, 5, 5, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 0, 0, 6, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 0, 0, 7, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 0, 0, 7, 1, 0));
        tv.push_back(mk(1, 1, 2'b01, 0, 0, 7, 1, 0));
        // One-shot down from 2, frozen in DONE, reload of 3 restarts.
        tv.push_back(mk(0, 0, 2'b10, 1, 2, 2, 0, 0));
        tv.push_back(mk(1, 0, 2'b10, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 2'b10, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 2'b10, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 2'b10, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 2'b10, 1, 3, 3, 0, 0));
        tv.push_back(mk(1, 0, 2'b10, 0, 0, 2, 0, 0));
        // Reserved mode behaves as wrap.
        tv.push_back(mk(0, 1, 2'b11, 1, 7, 7, 0, 0));
        tv.push_back(mk(1, 1, 2'b11, 0, 0, 0, 1, 0));

        // Reset state, then release between edges.
        #12;
        ma = mreset(7);
        mb = mreset(3);
        chk("reset.a.count", int'(count_a), 7);
        chk("reset.b.count", int'(count_b), 3);
        chk("reset.tc",      int'(tc_a | tc_b), 0);
        chk("reset.done",    int'(done_a | done_b), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            step("tbl", tv[i].e, tv[i].u, tv[i].md, tv[i].ld, tv[i].lv);
            chk($sformatf("tbl%0d.count", i), int'(count_a), tv[i].ecnt);
            chk($sformatf("tbl%0d.tc", i),    int'(tc_a),    int'(tv[i].etc));
            chk($sformatf("tbl%0d.done", i),  int'(done_a),  int'(tv[i].edone));
        end

        // Instance B prescaler: en 1,1,0,1 steps only on the third enabled cycle.
        step("ps", 0, 1, 2'b00, 1, 0);
        step("ps", 1, 1, 2'b00, 0, 0);
        step("ps", 1, 1, 2'b00, 0, 0);
        step("ps", 0, 1, 2'b00, 0, 0);
        chk("ps.pause.b", int'(count_b), 0);
        step("ps", 1, 1, 2'b00, 0, 0);
        chk("ps.step.b", int'(count_b), 1);
        // Load mid-prescale clears the phase: three more enabled cycles needed.
        step("ps", 1, 1, 2'b00, 0, 0);
        step("ps", 0, 1, 2'b00, 1, 2);
        step("ps", 1, 1, 2'b00, 0, 0);
        step("ps", 1, 1, 2'b00, 0, 0);
        chk("ps.clr.b", int'(count_b), 2);
        step("ps", 1, 1, 2'b00, 0, 0);
        chk("ps.clr_step.b", int'(count_b), 3);

        // Clamped load on MAX=5, then wrap to 0 with tc.
        step("mx", 0, 1, 2'b00, 1, 7);
        chk("mx.clamp.b", int'(count_b), 5);
        step("mx", 1, 1, 2'b00, 0, 0);
        step("mx", 1, 1, 2'b00, 0, 0);
        step("mx", 1, 1, 2'b00, 0, 0);
        chk("mx.wrap.b", int'(count_b), 0);
        chk("mx.wrap_tc.b", int'(tc_b), 1);
        // Load on the same edge as a due step: load wins, no tc.
        step("mx", 1, 1, 2'b00, 0, 0);
        step("mx", 1, 1, 2'b00, 0, 0);
        step("mx", 1, 1, 2'b00, 1, 4);
        chk("mx.ldstep.b", int'(count_b), 4);
        chk("mx.ldstep_tc.b", int'(tc_b), 0);

        // Reset mid-count and mid-prescale (B at count 4, phase 1).
        step("rs", 0, 1, 2'b00, 1, 3);
        step("rs", 1, 1, 2'b00, 0, 0);
        step("rs", 1, 1, 2'b00, 0, 0);
        step("rs", 1, 1, 2'b00, 0, 0);
        step("rs", 1, 1, 2'b00, 0, 0);
        chk("rs.pre.b", int'(count_b), 4);
        do_reset("rs.async");
        step("rs", 1, 1, 2'b00, 0, 0);
        step("rs", 1, 1, 2'b00, 0, 0);
        chk("rs.resume_wait.b", int'(count_b), 3);
        step("rs", 1, 1, 2'b00, 0, 0);
        chk("rs.resume.b", int'(count_b), 4);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd.reset");
            end else begin
                step("rnd", $urandom_range(0, 3) != 0, 1'($urandom),
                     2'($urandom), $urandom_range(0, 9) == 0, 3'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end by 200000");
        $fatal(1);
    end

endmodule
